cache_mem_bridge: RTL and testbench

Miss-handling burst engine between the 4-way cache data array and main memory. It accepts one block request from the cache. If the victim line is dirty, it first writes the 64-byte victim back as 8 x 64-bit beats. It then reads the 64-byte refill block as 8 beats and returns each beat to the cache with its beat index. It pulses `done` when the line is complete.

---
 rtl/cache_mem_bridge_if.sv | 70 +++++++
 rtl/cache_mem_bridge.sv | 206 ++++++++++++++++++++
 tb/tb_cache_mem_bridge.sv | 538 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_mem_bridge_if.sv
// cache_mem_bridge_if
// Bundles every handshake and data signal between the miss-handling bridge,
// the cache data array and main memory.
// Parameters:
//   ADDR_WIDTH - byte address width on both the cache and memory side
//   MEM_WIDTH  - width of one memory data beat
//   BEAT_W     - width of a beat index within one block
// Modports:
//   master - the bridge: accepts cache requests and drives the memory commands
//   slave  - the environment: the cache front end plus the memory controller
interface cache_mem_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_WIDTH  = 64,
  parameter int BEAT_W     = 3
);

  // cache request side
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_rd_addr;
  logic                  req_wb;
  logic [ADDR_WIDTH-1:0] req_wb_addr;

  // victim read-out from the cache data array
  logic [BEAT_W-1:0]     wb_beat;
  logic [MEM_WIDTH-1:0]  wb_data;

  // refill beats back to the cache, plus status
  logic                  fill_valid;
  logic [BEAT_W-1:0]     fill_beat;
  logic [MEM_WIDTH-1:0]  fill_data;
  logic                  done;
  logic                  err;

  // memory command channel
  logic                  mem_cmd_valid;
  logic                  mem_cmd_ready;
  logic                  mem_cmd_we;
  logic [ADDR_WIDTH-1:0] mem_cmd_addr;

  // memory write-data channel
  logic                  mem_wdata_valid;
  logic                  mem_wdata_ready;
  logic [MEM_WIDTH-1:0]  mem_wdata;
  logic                  mem_wdata_last;

  // memory read-data channel (no backpressure)
  logic                  mem_rdata_valid;
  logic [MEM_WIDTH-1:0]  mem_rdata;
  logic                  mem_rdata_last;

  modport master (
    input  req_valid, req_rd_addr, req_wb, req_wb_addr, wb_data,
           mem_cmd_ready, mem_wdata_ready,
           mem_rdata_valid, mem_rdata, mem_rdata_last,
    output req_ready, wb_beat, fill_valid, fill_beat, fill_data, done, err,
           mem_cmd_valid, mem_cmd_we, mem_cmd_addr,
           mem_wdata_valid, mem_wdata, mem_wdata_last
  );

  modport slave (
    output req_valid, req_rd_addr, req_wb, req_wb_addr, wb_data,
           mem_cmd_ready, mem_wdata_ready,
           mem_rdata_valid, mem_rdata, mem_rdata_last,
    input  req_ready, wb_beat, fill_valid, fill_beat, fill_data, done, err,
           mem_cmd_valid, mem_cmd_we, mem_cmd_addr,
           mem_wdata_valid, mem_wdata, mem_wdata_last
  );

endinterface

// File: rtl/cache_mem_bridge.sv
// cache_mem_bridge
// Miss-handling burst engine between the cache data array and main memory.
// One line request is taken at a time. A dirty victim is first written back
// as a burst of beats, then the refill block is read as a burst of beats and
// every beat is handed to the cache with its index. done pulses together
// with the last refill beat.
// Ports:
//   clk   - single clock, all state changes on the rising edge
//   rst_n - asynchronous active-low reset; abandons any burst in flight
//   bus   - cache_mem_bridge_if.master: cache request, victim read-out,
//           refill return, status, and the memory command/write/read channels
module cache_mem_bridge #(
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_WIDTH   = 64,
  parameter int BLOCK_BYTES = 64
) (
  input logic                clk,
  input logic                rst_n,
  cache_mem_bridge_if.master bus
);

  localparam int NBEATS = (BLOCK_BYTES * 8) / MEM_WIDTH;
  localparam int BEAT_W = $clog2(NBEATS);
  localparam logic [BEAT_W-1:0]     LAST_BEAT   = BEAT_W'(NBEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'(BLOCK_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WB_CMD  = 3'd1,
    WB_DATA = 3'd2,
    RD_CMD  = 3'd3,
    RD_DATA = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t                state;
  state_t                state_nxt;

  logic [BEAT_W-1:0]     beat_cnt;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH-1:0] wb_addr;

  logic                  fill_valid_q;
  logic [BEAT_W-1:0]     fill_beat_q;
  logic [MEM_WIDTH-1:0]  fill_data_q;
  logic                  err_q;

  logic                  at_last_beat;
  logic                  proto_err;

  assign at_last_beat = (beat_cnt == LAST_BEAT);

  assign bus.fill_valid = fill_valid_q;
  assign bus.fill_beat  = fill_beat_q;
  assign bus.fill_data  = fill_data_q;
  assign bus.err        = err_q;

  // State register. Reset drops straight back to IDLE so a burst in flight
  // is simply forgotten; the memory side is expected to be reset with us.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and all handshake outputs. Everything here is a pure
  // function of the state, the beat counter and the latched addresses, so
  // command and write-data outputs cannot move while memory stalls.
  // The write burst ends on the counter alone; the read burst likewise ends
  // on the counter, never on mem_rdata_last.
  always_comb begin
    state_nxt           = state;
    bus.req_ready       = 1'b0;
    bus.mem_cmd_valid   = 1'b0;
    bus.mem_cmd_we      = 1'b0;
    bus.mem_cmd_addr    = '0;
    bus.mem_wdata_valid = 1'b0;
    bus.mem_wdata       = '0;
    bus.mem_wdata_last  = 1'b0;
    bus.wb_beat         = '0;
    bus.done            = 1'b0;

    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          state_nxt = bus.req_wb ? WB_CMD : RD_CMD;
        end
      end

      WB_CMD: begin
        bus.mem_cmd_valid = 1'b1;
        bus.mem_cmd_we    = 1'b1;
        bus.mem_cmd_addr  = wb_addr;
        if (bus.mem_cmd_ready) begin
          state_nxt = WB_DATA;
        end
      end

      WB_DATA: begin
        bus.mem_wdata_valid = 1'b1;
        bus.wb_beat         = beat_cnt;
        bus.mem_wdata       = bus.wb_data;
        bus.mem_wdata_last  = at_last_beat;
        if (bus.mem_wdata_ready && at_last_beat) begin
          state_nxt = RD_CMD;
        end
      end

      RD_CMD: begin
        bus.mem_cmd_valid = 1'b1;
        bus.mem_cmd_we    = 1'b0;
        bus.mem_cmd_addr  = rd_addr;
        if (bus.mem_cmd_ready) begin
          state_nxt = RD_DATA;
        end
      end

      RD_DATA: begin
        if (bus.mem_rdata_valid && at_last_beat) begin
          state_nxt = DONE;
        end
      end

      DONE: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Read-channel protocol check. Any read beat outside the refill burst is
  // an error, as is a last flag that disagrees with the beat count.
  always_comb begin
    proto_err = 1'b0;
    if (bus.mem_rdata_valid) begin
      if (state != RD_DATA) begin
        proto_err = 1'b1;
      end else if (bus.mem_rdata_last != at_last_beat) begin
        proto_err = 1'b1;
      end
    end
  end

  // Datapath: address latches, the shared beat counter, the registered
  // refill return and the sticky error flag. The counter is cleared each
  // time a command is accepted; its natural wrap after the final beat
  // coincides with leaving the data state, so it never wraps mid-burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt     <= '0;
      rd_addr      <= '0;
      wb_addr      <= '0;
      fill_valid_q <= 1'b0;
      fill_beat_q  <= '0;
      fill_data_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      fill_valid_q <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            rd_addr <= bus.req_rd_addr & ~OFFSET_MASK;
            wb_addr <= bus.req_wb_addr & ~OFFSET_MASK;
          end
        end

        WB_CMD, RD_CMD: begin
          if (bus.mem_cmd_ready) begin
            beat_cnt <= '0;
          end
        end

        WB_DATA: begin
          if (bus.mem_wdata_ready) begin
            beat_cnt <= beat_cnt + BEAT_W'(1);
          end
        end

        RD_DATA: begin
          if (bus.mem_rdata_valid) begin
            fill_valid_q <= 1'b1;
            fill_beat_q  <= beat_cnt;
            fill_data_q  <= bus.mem_rdata;
            beat_cnt     <= beat_cnt + BEAT_W'(1);
          end
        end

        default: begin
        end
      endcase

      if (proto_err) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cache_mem_bridge.sv
// tb_cache_mem_bridge
// Self-checking bench for cache_mem_bridge. A cycle-level driver plays the
// cache and the memory controller, records what the bridge emits, and each
// test task compares the record with expectations computed from the block
// rules (aligned addresses, beat order, latencies, error conditions).
module tb_cache_mem_bridge;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  cache_mem_bridge_if bus ();

  cache_mem_bridge dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [63:0] victim    [8];
  logic [63:0] rdata_blk [8];

  // The cache data array answers the victim beat index combinationally.
  assign bus.wb_data = victim[bus.wb_beat];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  bit          obs_cmd_we   [$];
  logic [31:0] obs_cmd_addr [$];
  int          obs_cmd_len  [$];
  logic [2:0]  obs_w_beat   [$];
  logic [63:0] obs_w_data   [$];
  bit          obs_w_last   [$];
  logic [2:0]  obs_f_beat   [$];
  logic [63:0] obs_f_data   [$];
  int          obs_f_cyc    [$];
  int          drv_r_cyc    [$];

  int done_cnt, done_cyc, done_no_fill, accept_cyc;
  int cmd_unstable, wdata_unstable, wr_cycles, wr_stall, idle_wb_beat;
  bit cmd_after_accept, ready_back, timeout, aborted;

  // Watchdog so a wedged run still ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got simulation still running want finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clear_inputs();
    bus.req_valid       = 1'b0;
    bus.req_rd_addr     = '0;
    bus.req_wb          = 1'b0;
    bus.req_wb_addr     = '0;
    bus.mem_cmd_ready   = 1'b0;
    bus.mem_wdata_ready = 1'b0;
    bus.mem_rdata_valid = 1'b0;
    bus.mem_rdata       = '0;
    bus.mem_rdata_last  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Plays one line transaction cycle by cycle and records the bridge's
  // behaviour. wmode: 0 ready always, 1 ready toggles starting low,
  // 2 random. last_idx is the read beat carrying mem_rdata_last.
  // abort_beat >= 0 pulls reset just before that read beat is sent.
  task automatic drive_txn(input logic [31:0] rd_a, input bit wb,
                           input logic [31:0] wb_a, input int cmd_wait,
                           input int wmode, input int lat, input bit rgaps,
                           input int last_idx, input int abort_beat);
    int          cmd_len = 0;
    bit          held_we = 1'b0;
    logic [31:0] held_addr = '0;
    bit          req_sent = 1'b0;
    bit          accept_pending = 1'b0;
    bit          rd_started = 1'b0;
    int          rd_delay = 0;
    int          rsent = 0;
    bit          saw_done = 1'b0;
    bit          finished = 1'b0;
    bit          wheld = 1'b0;
    logic [2:0]  h_beat = '0;
    logic [63:0] h_data = '0;
    bit          h_last = 1'b0;
    int          wphase = 0;
    bit          r;

    obs_cmd_we.delete(); obs_cmd_addr.delete(); obs_cmd_len.delete();
    obs_w_beat.delete(); obs_w_data.delete(); obs_w_last.delete();
    obs_f_beat.delete(); obs_f_data.delete(); obs_f_cyc.delete();
    drv_r_cyc.delete();
    done_cnt = 0; done_cyc = 0; done_no_fill = 0; accept_cyc = 0;
    cmd_unstable = 0; wdata_unstable = 0; wr_cycles = 0; wr_stall = 0;
    idle_wb_beat = 0; cmd_after_accept = 1'b0; ready_back = 1'b0;
    timeout = 1'b0; aborted = 1'b0;

    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      cyc++;

      if (bus.fill_valid) begin
        obs_f_beat.push_back(bus.fill_beat);
        obs_f_data.push_back(bus.fill_data);
        obs_f_cyc.push_back(cyc);
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
        if (!bus.fill_valid) done_no_fill++;
      end
      if (!bus.mem_wdata_valid && bus.wb_beat !== 3'd0) idle_wb_beat++;

      if (saw_done) begin
        ready_back = bus.req_ready;
        finished = 1'b1;
        break;
      end
      if (bus.done) saw_done = 1'b1;

      if (accept_pending) begin
        cmd_after_accept = bus.mem_cmd_valid;
        accept_pending = 1'b0;
      end

      if (!req_sent && bus.req_ready) begin
        bus.req_valid   = 1'b1;
        bus.req_rd_addr = rd_a;
        bus.req_wb      = wb;
        bus.req_wb_addr = wb_a;
        req_sent = 1'b1;
        accept_pending = 1'b1;
        accept_cyc = cyc;
      end else begin
        bus.req_valid   = 1'b0;
        bus.req_rd_addr = $urandom;
        bus.req_wb      = 1'($urandom_range(0, 1));
        bus.req_wb_addr = $urandom;
      end

      if (abort_beat >= 0 && rd_started && rsent == abort_beat && rd_delay == 0) begin
        rst_n = 1'b0;
        clear_inputs();
        aborted = 1'b1;
        return;
      end

      if (rd_started && rsent < 8) begin
        if (rd_delay > 0) begin
          rd_delay--;
          bus.mem_rdata_valid = 1'b0;
        end else if (rgaps && $urandom_range(0, 3) == 0) begin
          bus.mem_rdata_valid = 1'b0;
        end else begin
          bus.mem_rdata_valid = 1'b1;
          bus.mem_rdata       = rdata_blk[rsent];
          bus.mem_rdata_last  = (rsent == last_idx);
          drv_r_cyc.push_back(cyc);
          rsent++;
        end
      end else begin
        bus.mem_rdata_valid = 1'b0;
        bus.mem_rdata       = {$urandom, $urandom};
        bus.mem_rdata_last  = 1'($urandom_range(0, 1));
      end

      if (bus.mem_cmd_valid) begin
        if (cmd_len == 0) begin
          held_we   = bus.mem_cmd_we;
          held_addr = bus.mem_cmd_addr;
        end else if (bus.mem_cmd_we !== held_we || bus.mem_cmd_addr !== held_addr) begin
          cmd_unstable++;
        end
        cmd_len++;
        if (cmd_len > cmd_wait) begin
          bus.mem_cmd_ready = 1'b1;
          obs_cmd_we.push_back(bus.mem_cmd_we);
          obs_cmd_addr.push_back(bus.mem_cmd_addr);
          obs_cmd_len.push_back(cmd_len);
          if (!bus.mem_cmd_we) begin
            rd_started = 1'b1;
            rd_delay = lat;
          end
          cmd_len = 0;
        end else begin
          bus.mem_cmd_ready = 1'b0;
        end
      end else begin
        bus.mem_cmd_ready = 1'($urandom_range(0, 1));
      end

      if (bus.mem_wdata_valid) begin
        wr_cycles++;
        if (wheld && (bus.wb_beat !== h_beat || bus.mem_wdata !== h_data ||
                      bus.mem_wdata_last !== h_last)) begin
          wdata_unstable++;
        end
        case (wmode)
          0:       r = 1'b1;
          1:       r = (wphase % 2 == 1);
          default: r = 1'($urandom_range(0, 1));
        endcase
        wphase++;
        bus.mem_wdata_ready = r;
        if (r) begin
          obs_w_beat.push_back(bus.wb_beat);
          obs_w_data.push_back(bus.mem_wdata);
          obs_w_last.push_back(bus.mem_wdata_last);
          wheld = 1'b0;
        end else begin
          wheld  = 1'b1;
          h_beat = bus.wb_beat;
          h_data = bus.mem_wdata;
          h_last = bus.mem_wdata_last;
          wr_stall++;
        end
      end else begin
        bus.mem_wdata_ready = 1'($urandom_range(0, 1));
      end
    end

    clear_inputs();
    if (!finished) timeout = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    for (int i = 0; i < 8; i++) victim[i] = 64'hA5A5_0000_0000_0000 | 64'(i + 1);
    repeat (3) @(negedge clk);
    total++;
    if (bus.req_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL reset_req_ready: got %b want 1", bus.req_ready);
    end
    total++;
    if ({bus.mem_cmd_valid, bus.mem_cmd_we, bus.mem_wdata_valid, bus.mem_wdata_last} !== 4'b0) begin
      bad++; $display("[TB] FAIL reset_mem_ctrl: got %b want 0000",
                      {bus.mem_cmd_valid, bus.mem_cmd_we, bus.mem_wdata_valid, bus.mem_wdata_last});
    end
    total++;
    if ({bus.fill_valid, bus.done, bus.err} !== 3'b0) begin
      bad++; $display("[TB] FAIL reset_status: got %b want 000", {bus.fill_valid, bus.done, bus.err});
    end
    total++;
    if (bus.mem_cmd_addr !== 32'h0 || bus.mem_wdata !== 64'h0) begin
      bad++; $display("[TB] FAIL reset_mem_bus: got addr=%h wdata=%h want 0", bus.mem_cmd_addr, bus.mem_wdata);
    end
    total++;
    if (bus.fill_beat !== 3'd0 || bus.fill_data !== 64'h0 || bus.wb_beat !== 3'd0) begin
      bad++; $display("[TB] FAIL reset_beats: got fill_beat=%0d fill_data=%h wb_beat=%0d want 0",
                      bus.fill_beat, bus.fill_data, bus.wb_beat);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (bus.req_ready !== 1'b1 || bus.mem_cmd_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_release: got ready=%b cmd_valid=%b want 1 0",
                      bus.req_ready, bus.mem_cmd_valid);
    end
  endtask

  task automatic test_clean_miss();
    for (int i = 0; i < 8; i++) rdata_blk[i] = 64'(i);
    drive_txn(32'h0000_1234, 1'b0, 32'h0, 0, 0, 2, 1'b0, 7, -1);
    total++;
    if (timeout) begin bad++; $display("[TB] FAIL clean_timeout: got timeout want done"); end
    total++;
    if (obs_cmd_addr.size() != 1) begin
      bad++; $display("[TB] FAIL clean_cmd_count: got %0d want 1", obs_cmd_addr.size());
    end else if (obs_cmd_addr[0] !== 32'h0000_1200 || obs_cmd_we[0] !== 1'b0) begin
      bad++; $display("[TB] FAIL clean_cmd: got addr=%h we=%b want 00001200 0", obs_cmd_addr[0], obs_cmd_we[0]);
    end
    total++;
    if (!cmd_after_accept) begin bad++; $display("[TB] FAIL clean_cmd_latency: got cmd_valid=0 want 1 at T+1"); end
    total++;
    if (obs_f_beat.size() != 8) begin
      bad++; $display("[TB] FAIL clean_fill_count: got %0d want 8", obs_f_beat.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        total++;
        if (obs_f_beat[i] !== 3'(i) || obs_f_data[i] !== 64'(i) || obs_f_cyc[i] != drv_r_cyc[i] + 1) begin
          bad++; $display("[TB] FAIL clean_fill%0d: got beat=%0d data=%h cyc=%0d want beat=%0d data=%h cyc=%0d",
                          i, obs_f_beat[i], obs_f_data[i], obs_f_cyc[i], i, 64'(i), drv_r_cyc[i] + 1);
        end
      end
    end
    total++;
    if (done_cnt != 1 || done_no_fill != 0 || !ready_back) begin
      bad++; $display("[TB] FAIL clean_done: got done=%0d lonely=%0d ready_back=%b want 1 0 1",
                      done_cnt, done_no_fill, ready_back);
    end
    total++;
    if (done_cyc - accept_cyc != 12) begin
      bad++; $display("[TB] FAIL clean_total_cycles: got %0d want 12", done_cyc - accept_cyc);
    end
    total++;
    if (bus.err !== 1'b0) begin bad++; $display("[TB] FAIL clean_err: got %b want 0", bus.err); end
  endtask

  task automatic test_dirty_miss();
    logic [31:0] rd_a = $urandom;
    for (int i = 0; i < 8; i++) begin
      victim[i]    = {$urandom, $urandom};
      rdata_blk[i] = {$urandom, $urandom};
    end
    drive_txn(rd_a, 1'b1, 32'h0000_ABFF, 0, 0, 1, 1'b0, 7, -1);
    total++;
    if (timeout) begin bad++; $display("[TB] FAIL dirty_timeout: got timeout want done"); end
    total++;
    if (obs_cmd_addr.size() != 2) begin
      bad++; $display("[TB] FAIL dirty_cmd_count: got %0d want 2", obs_cmd_addr.size());
    end else if (obs_cmd_we[0] !== 1'b1 || obs_cmd_addr[0] !== 32'h0000_ABC0 ||
                 obs_cmd_we[1] !== 1'b0 || obs_cmd_addr[1] !== (rd_a / 64) * 64) begin
      bad++; $display("[TB] FAIL dirty_cmds: got %b/%h %b/%h want 1/0000abc0 0/%h",
                      obs_cmd_we[0], obs_cmd_addr[0], obs_cmd_we[1], obs_cmd_addr[1], (rd_a / 64) * 64);
    end
    total++;
    if (obs_w_beat.size() != 8) begin
      bad++; $display("[TB] FAIL dirty_write_count: got %0d want 8", obs_w_beat.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        total++;
        if (obs_w_beat[i] !== 3'(i) || obs_w_data[i] !== victim[i] || obs_w_last[i] !== (i == 7)) begin
          bad++; $display("[TB] FAIL dirty_write%0d: got beat=%0d data=%h last=%b want %0d %h %b",
                          i, obs_w_beat[i], obs_w_data[i], obs_w_last[i], i, victim[i], i == 7);
        end
      end
    end
    total++;
    if (obs_f_beat.size() != 8) begin
      bad++; $display("[TB] FAIL dirty_fill_count: got %0d want 8", obs_f_beat.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        total++;
        if (obs_f_beat[i] !== 3'(i) || obs_f_data[i] !== rdata_blk[i]) begin
          bad++; $display("[TB] FAIL dirty_fill%0d: got beat=%0d data=%h want %0d %h",
                          i, obs_f_beat[i], obs_f_data[i], i, rdata_blk[i]);
        end
      end
    end
    total++;
    if (done_cnt != 1 || done_no_fill != 0 || idle_wb_beat != 0 || bus.err !== 1'b0) begin
      bad++; $display("[TB] FAIL dirty_status: got done=%0d lonely=%0d idle_wb=%0d err=%b want 1 0 0 0",
                      done_cnt, done_no_fill, idle_wb_beat, bus.err);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd_a = $urandom;
    logic [31:0] wb_a = $urandom;
    for (int i = 0; i < 8; i++) begin
      victim[i]    = {$urandom, $urandom};
      rdata_blk[i] = {$urandom, $urandom};
    end
    drive_txn(rd_a, 1'b1, wb_a, 3, 1, 0, 1'b0, 7, -1);
    total++;
    if (timeout) begin bad++; $display("[TB] FAIL bp_timeout: got timeout want done"); end
    total++;
    if (obs_cmd_len.size() != 2 || obs_cmd_len[0] != 4 || obs_cmd_len[1] != 4 || cmd_unstable != 0) begin
      bad++; $display("[TB] FAIL bp_cmd_hold: got n=%0d unstable=%0d want two holds of 4 cycles, 0 unstable",
                      obs_cmd_len.size(), cmd_unstable);
    end
    total++;
    if (wr_cycles != 16 || wdata_unstable != 0) begin
      bad++; $display("[TB] FAIL bp_write_phase: got cycles=%0d unstable=%0d want 16 0", wr_cycles, wdata_unstable);
    end
    total++;
    if (obs_w_beat.size() != 8) begin
      bad++; $display("[TB] FAIL bp_write_count: got %0d want 8", obs_w_beat.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        total++;
        if (obs_w_beat[i] !== 3'(i) || obs_w_data[i] !== victim[i]) begin
          bad++; $display("[TB] FAIL bp_write%0d: got beat=%0d data=%h want %0d %h",
                          i, obs_w_beat[i], obs_w_data[i], i, victim[i]);
        end
      end
    end
    total++;
    if (obs_f_beat.size() != 8 || done_cnt != 1 || bus.err !== 1'b0) begin
      bad++; $display("[TB] FAIL bp_finish: got fills=%0d done=%0d err=%b want 8 1 0",
                      obs_f_beat.size(), done_cnt, bus.err);
    end
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 6; t++) begin
      logic [31:0] rd_a = $urandom;
      logic [31:0] wb_a = $urandom;
      bit          wb   = 1'($urandom_range(0, 1));
      int          ncmd = wb ? 2 : 1;
      for (int i = 0; i < 8; i++) begin
        victim[i]    = {$urandom, $urandom};
        rdata_blk[i] = {$urandom, $urandom};
      end
      drive_txn(rd_a, wb, wb_a, $urandom_range(0, 3), 2, $urandom_range(0, 4), 1'b1, 7, -1);
      total++;
      if (timeout) begin bad++; $display("[TB] FAIL b2b%0d_timeout: got timeout want done", t); end
      total++;
      if (obs_cmd_addr.size() != ncmd) begin
        bad++; $display("[TB] FAIL b2b%0d_cmd_count: got %0d want %0d", t, obs_cmd_addr.size(), ncmd);
      end else begin
        total++;
        if (obs_cmd_we[ncmd-1] !== 1'b0 || obs_cmd_addr[ncmd-1] !== (rd_a / 64) * 64 ||
            (wb && (obs_cmd_we[0] !== 1'b1 || obs_cmd_addr[0] !== (wb_a / 64) * 64))) begin
          bad++; $display("[TB] FAIL b2b%0d_cmds: got last=%b/%h first=%b/%h want rd %h wb %h",
                          t, obs_cmd_we[ncmd-1], obs_cmd_addr[ncmd-1], obs_cmd_we[0], obs_cmd_addr[0],
                          (rd_a / 64) * 64, (wb_a / 64) * 64);
        end
      end
      total++;
      if (obs_w_beat.size() != (wb ? 8 : 0) || wr_cycles != (wb ? 8 + wr_stall : 0) || wdata_unstable != 0) begin
        bad++; $display("[TB] FAIL b2b%0d_write_phase: got beats=%0d cycles=%0d unstable=%0d want %0d %0d 0",
                        t, obs_w_beat.size(), wr_cycles, wdata_unstable, wb ? 8 : 0, wb ? 8 + wr_stall : 0);
      end else begin
        for (int i = 0; i < obs_w_beat.size(); i++) begin
          total++;
          if (obs_w_beat[i] !== 3'(i) || obs_w_data[i] !== victim[i] || obs_w_last[i] !== (i == 7)) begin
            bad++; $display("[TB] FAIL b2b%0d_write%0d: got beat=%0d data=%h last=%b want %0d %h %b",
                            t, i, obs_w_beat[i], obs_w_data[i], obs_w_last[i], i, victim[i], i == 7);
          end
        end
      end
      total++;
      if (obs_f_beat.size() != 8) begin
        bad++; $display("[TB] FAIL b2b%0d_fill_count: got %0d want 8", t, obs_f_beat.size());
      end else begin
        for (int i = 0; i < 8; i++) begin
          total++;
          if (obs_f_beat[i] !== 3'(i) || obs_f_data[i] !== rdata_blk[i] || obs_f_cyc[i] != drv_r_cyc[i] + 1) begin
            bad++; $display("[TB] FAIL b2b%0d_fill%0d: got beat=%0d data=%h cyc=%0d want %0d %h %0d",
                            t, i, obs_f_beat[i], obs_f_data[i], obs_f_cyc[i], i, rdata_blk[i], drv_r_cyc[i] + 1);
          end
        end
      end
      total++;
      if (done_cnt != 1 || done_no_fill != 0 || !ready_back || !cmd_after_accept || bus.err !== 1'b0) begin
        bad++; $display("[TB] FAIL b2b%0d_status: got done=%0d lonely=%0d ready_back=%b cmd_t1=%b err=%b want 1 0 1 1 0",
                        t, done_cnt, done_no_fill, ready_back, cmd_after_accept, bus.err);
      end
    end
  endtask

  task automatic test_rdata_last_err();
    for (int i = 0; i < 8; i++) rdata_blk[i] = {$urandom, $urandom};
    drive_txn($urandom, 1'b0, 32'h0, 0, 0, 1, 1'b0, 5, -1);
    total++;
    if (timeout || obs_f_beat.size() != 8 || done_cnt != 1) begin
      bad++; $display("[TB] FAIL lasterr_complete: got timeout=%b fills=%0d done=%0d want 0 8 1",
                      timeout, obs_f_beat.size(), done_cnt);
    end
    total++;
    if (bus.err !== 1'b1) begin bad++; $display("[TB] FAIL lasterr_flag: got %b want 1", bus.err); end
    repeat (3) @(negedge clk);
    total++;
    if (bus.err !== 1'b1 || bus.req_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL lasterr_sticky: got err=%b ready=%b want 1 1", bus.err, bus.req_ready);
    end
  endtask

  task automatic test_spurious_idle();
    do_reset();
    total++;
    if (bus.err !== 1'b0) begin bad++; $display("[TB] FAIL spur_pre_err: got %b want 0", bus.err); end
    bus.mem_rdata_valid = 1'b1;
    bus.mem_rdata       = {$urandom, $urandom};
    bus.mem_rdata_last  = 1'b0;
    @(negedge clk);
    bus.mem_rdata_valid = 1'b0;
    total++;
    if (bus.fill_valid !== 1'b0 || bus.err !== 1'b1 || bus.req_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL spur_idle: got fill_valid=%b err=%b ready=%b want 0 1 1",
                      bus.fill_valid, bus.err, bus.req_ready);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    for (int i = 0; i < 8; i++) rdata_blk[i] = {$urandom, $urandom};
    drive_txn($urandom, 1'b0, 32'h0, 0, 0, 1, 1'b0, 7, 3);
    total++;
    if (!aborted || obs_f_beat.size() != 3) begin
      bad++; $display("[TB] FAIL midrst_reach: got aborted=%b fills=%0d want 1 3", aborted, obs_f_beat.size());
    end
    #1;
    total++;
    if (bus.req_ready !== 1'b1 || {bus.fill_valid, bus.done, bus.err, bus.mem_cmd_valid, bus.mem_wdata_valid} !== 5'b0) begin
      bad++; $display("[TB] FAIL midrst_outputs: got ready=%b flags=%b want 1 00000", bus.req_ready,
                      {bus.fill_valid, bus.done, bus.err, bus.mem_cmd_valid, bus.mem_wdata_valid});
    end
    total++;
    if (bus.fill_beat !== 3'd0 || bus.fill_data !== 64'h0 || bus.mem_cmd_addr !== 32'h0) begin
      bad++; $display("[TB] FAIL midrst_data: got beat=%0d data=%h addr=%h want 0 0 0",
                      bus.fill_beat, bus.fill_data, bus.mem_cmd_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) rdata_blk[i] = {$urandom, $urandom};
    drive_txn(32'h0000_4040, 1'b0, 32'h0, 0, 0, 2, 1'b0, 7, -1);
    total++;
    if (timeout || obs_cmd_addr.size() != 1 || obs_f_beat.size() != 8 || done_cnt != 1 || bus.err !== 1'b0) begin
      bad++; $display("[TB] FAIL midrst_recover: got timeout=%b cmds=%0d fills=%0d done=%0d err=%b want 0 1 8 1 0",
                      timeout, obs_cmd_addr.size(), obs_f_beat.size(), done_cnt, bus.err);
    end else begin
      for (int i = 0; i < 8; i++) begin
        total++;
        if (obs_f_beat[i] !== 3'(i) || obs_f_data[i] !== rdata_blk[i]) begin
          bad++; $display("[TB] FAIL midrst_fill%0d: got beat=%0d data=%h want %0d %h",
                          i, obs_f_beat[i], obs_f_data[i], i, rdata_blk[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_miss();
    test_dirty_miss();
    test_backpressure();
    test_back_to_back();
    test_rdata_last_err();
    test_spurious_idle();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
